// File: rtl/lap_stop_watch_pkg.sv
// Shared constants for the lap stopwatch.
// Holds the digit limits, the digit index map (LSB first) and the helpers
// that derive the total count width and the per-digit limit.
package lap_stop_watch_pkg;

    localparam int DIG_MAX      = 9;  // tenths, seconds units, minute digits
    localparam int SEC_TENS_MAX = 5;  // seconds tens

    localparam int IDX_TENTHS = 0;
    localparam int IDX_SEC_U  = 1;
    localparam int IDX_SEC_T  = 2;
    localparam int IDX_MIN0   = 3;

    // Total BCD count width: three sub-minute digits plus the minute digits.
    function automatic int count_w(input int n_min);
        return 4 * (n_min + 3);
    endfunction

    // Largest value a digit at position idx may hold.
    function automatic int digit_max(input int idx);
        return (idx == IDX_SEC_T) ? SEC_TENS_MAX : DIG_MAX;
    endfunction

endpackage

// File: rtl/lap_stop_watch_bcd_digit.sv
// One BCD digit of the stopwatch count.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   clr_i           synchronous clear (highest priority)
//   load_i          synchronous load of load_val_i, clamped to MAXV
//   load_val_i      preset value for this digit
//   up_i, dn_i      step direction for the whole counter (at most one high)
//   cin_i           carry/borrow in: this digit steps only when set
//   q_o             digit value
//   cout_o          carry/borrow out to the next digit (wrap in progress)
module bcd_digit #(
    parameter int MAXV = 9
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       up_i,
    input  logic       dn_i,
    input  logic       cin_i,
    output logic [3:0] q_o,
    output logic       cout_o
);

    localparam logic [3:0] MAXQ = 4'(MAXV);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (load_i) begin
            q_d = (load_val_i > MAXQ) ? MAXQ : load_val_i;
        end else if (cin_i && up_i) begin
            q_d = (q_q == MAXQ) ? 4'd0 : q_q + 4'd1;
        end else if (cin_i && dn_i) begin
            q_d = (q_q == 4'd0) ? MAXQ : q_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) q_q <= '0;
        else         q_q <= q_d;
    end

    assign q_o    = q_q;
    assign cout_o = cin_i && ((up_i && (q_q == MAXQ)) || (dn_i && (q_q == 4'd0)));

endmodule

// File: rtl/lap_stop_watch.sv
// BCD up/down stopwatch with lap hold, preset load and expire pulse.
// Ports:
//   clk, reset_n     clock, async active-low reset
//   clr              synchronous clear of count, lap, prescaler, expire
//   go / back        count up / count down (go wins) while held
//   load, preset     load preset (digits clamped) while idle
//   lap              toggle lap hold; capture count when entering hold
//   count            live BCD count, digits LSB first: tenths, s, 10s, minutes
//   disp             lap register while lap_active, else count
//   lap_active       lap hold in effect
//   at_max / at_zero count at all-9s.59.9 / zero
//   expire           one-cycle pulse after a down step lands on zero
module lap_stop_watch
    import lap_stop_watch_pkg::*;
#(
    parameter  int DVSR  = 10000000,
    parameter  int N_MIN = 1,
    localparam int W     = count_w(N_MIN)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         go,
    input  logic         back,
    input  logic         load,
    input  logic [W-1:0] preset,
    input  logic         lap,
    output logic [W-1:0] count,
    output logic [W-1:0] disp,
    output logic         lap_active,
    output logic         at_max,
    output logic         at_zero,
    output logic         expire
);

    localparam int ND = N_MIN + 3;
    localparam int PW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DVSR - 1);

    logic [PW-1:0] pre_q;
    logic [W-1:0]  lap_q;
    logic          lap_active_q;
    logic          expire_q;

    logic          run, tick, load_acc, up_en, dn_en;
    logic [ND:0]   carry;
    logic [ND-1:0] dig_max;
    logic          unused_carry;

    assign run      = go | back;
    assign tick     = run && (pre_q == PRE_LAST);
    assign load_acc = load && !clr && !run;
    // Saturating: no step is issued at the end stops, so no wrap ever starts.
    assign up_en    = !clr && tick && go && !at_max;
    assign dn_en    = !clr && tick && !go && back && !at_zero;

    assign carry[0]     = 1'b1;
    assign unused_carry = carry[ND];

    for (genvar i = 0; i < ND; i++) begin : g_dig
        bcd_digit #(.MAXV(digit_max(i))) u_dig (
            .clk_i      (clk),
            .rst_ni     (reset_n),
            .clr_i      (clr),
            .load_i     (load_acc),
            .load_val_i (preset[4*i +: 4]),
            .up_i       (up_en),
            .dn_i       (dn_en),
            .cin_i      (carry[i]),
            .q_o        (count[4*i +: 4]),
            .cout_o     (carry[i+1])
        );
        assign dig_max[i] = (count[4*i +: 4] == 4'(digit_max(i)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q        <= '0;
            lap_q        <= '0;
            lap_active_q <= 1'b0;
            expire_q     <= 1'b0;
        end else if (clr) begin
            pre_q        <= '0;
            lap_q        <= '0;
            lap_active_q <= 1'b0;
            expire_q     <= 1'b0;
        end else begin
            if (load_acc)  pre_q <= '0;
            else if (tick) pre_q <= '0;
            else if (run)  pre_q <= pre_q + 1'b1;

            // Captures the pre-step count when lap and tick coincide.
            if (lap) begin
                if (!lap_active_q) begin
                    lap_q        <= count;
                    lap_active_q <= 1'b1;
                end else begin
                    lap_active_q <= 1'b0;
                end
            end

            // Only a down step from exactly 0...0.1 lands on zero.
            expire_q <= dn_en && (count == W'(1));
        end
    end

    assign at_max     = &dig_max;
    assign at_zero    = (count == '0);
    assign lap_active = lap_active_q;
    assign disp       = lap_active_q ? lap_q : count;
    assign expire     = expire_q;

endmodule

// File: doc/lap_stop_watch.md
LAP_STOP_WATCH -- requirements
Module: lap_stop_watch

Interface
REQ-001 Parameter: DVSR, 10000000, tick divisor; one count step per DVSR clk cycles (>=2).
REQ-002 Parameter: N_MIN, 1, number of BCD minute digits (1..4).
REQ-003 Derived constant: W = 4*(N_MIN+3), total count width. Digit order LSB first: tenths, seconds units, seconds tens, then minute digits.
REQ-004 Port: clk  input  1  single clock, rising edge.
REQ-005 Port: reset_n  input  1  reset, asynchronous and active-low.
REQ-006 Port: clr  input  1  synchronous clear of count, lap and prescaler.
REQ-007 Port: go  input  1  level; count up while high.
REQ-008 Port: back  input  1  level; count down while high and go low.
REQ-009 Port: load  input  1  pulse; load preset while idle.
REQ-010 Port: preset  input  W  BCD preset value.
REQ-011 Port: lap  input  1  pulse; toggles lap hold.
REQ-012 Port: count  output  W  live BCD count.
REQ-013 Port: disp  output  W  displayed value: lap register when lap_active, else count.
REQ-014 Port: lap_active  output  1  lap hold in effect.
REQ-015 Port: at_max  output  1  count equals all-minutes-9.59.9.
REQ-016 Port: at_zero  output  1  count equals zero.
REQ-017 Port: expire  output  1  one-cycle pulse when a down step reaches zero.

Function
REQ-018 Priority each cycle SHALL be clr > go > back > load; run = go | back.
REQ-019 Prescaler SHALL count 0..DVSR-1 while run, hold while not run, clear on clr or accepted load; tick = run & (prescaler == DVSR-1); first step occurs DVSR cycles after run asserts.
REQ-020 On tick with go: tenths +1, wrap 9->0 with carry; seconds units wrap 9->0; seconds tens wrap 5->0; each minute digit wraps 9->0 into the next.
REQ-021 Up step at max SHALL leave count unchanged (saturate); at_max stays 1.
REQ-022 On tick with back and go low: tenths -1, borrow 0->9; seconds units 0->9; seconds tens 0->5; minute digits 0->9.
REQ-023 Down step at zero SHALL leave count unchanged; expire SHALL NOT pulse again.
REQ-024 expire SHALL be high for exactly the cycle after the edge on which count changed from nonzero to zero by a down step.
REQ-025 load SHALL be accepted only when clr=0, go=0, back=0; otherwise ignored. Any preset digit above its limit (9, or 5 for seconds tens) SHALL load as that limit.
REQ-026 lap pulse with lap_active=0 SHALL capture count into the lap register and set lap_active; with lap_active=1 SHALL clear lap_active. Counting is unaffected.
REQ-027 lap and tick in the same cycle SHALL capture the pre-step count.
REQ-028 clr SHALL zero count, lap register, lap_active, prescaler and expire on the next edge.
REQ-029 Reversing direction mid-prescale SHALL NOT reset the prescaler.
REQ-030 All outputs SHALL be registered or decoded from registers only.

Reset
REQ-031 reset_n low SHALL immediately force count, lap register, prescaler, lap_active and expire to 0; disp=0, at_zero=1, at_max=0.
REQ-032 Reset deassertion SHALL take effect synchronously to clk; the first step occurs DVSR cycles after run.

Structure
REQ-033 A shared package SHALL hold the digit limits (9, 5), the W function of N_MIN, and the digit-index constants.
REQ-034 One sub-module, bcd_digit (parameter MAXV), SHALL implement a digit with up/down enable, carry/borrow in/out, and a synchronous load; instantiate N_MIN+3 of them.

Verification (DVSR=4, N_MIN=1)
REQ-035 Reset, then go high for 40 cycles -> count 0.01.0. Before that, at cycle 4 count=0.00.1.
REQ-036 load 0.59.9, go held -> after 4 cycles count 1.00.0. load 9.59.9, go held -> count stays 9.59.9, at_max=1.
REQ-037 load 0.00.2, back held -> 0.00.1 at cycle 4 and 0.00.0 at cycle 8. expire is high for one cycle only. Count stays 0 afterwards.
REQ-038 At count 0.12.3 pulse lap -> disp frozen at 0.12.3 while count advances. Second lap pulse -> disp=count.
REQ-039 go and back both high -> counts up. load while go=1 -> ignored. clr with go=1 -> count 0 and prescaler 0.
REQ-040 reset_n low mid-count, between clk edges -> all outputs at reset values before the next edge.
